tag_release_buffer: RTL and testbench
=====================================

# tag_release_buffer

Collects tag-release requests from several writeback/retire sources and feeds them into the dispatcher's tag queue. The tag queue frees at most `NumTagIn` tags per cycle; this block absorbs bursts of up to `NumSrc` completions per cycle. It holds them in a small in-order FIFO and drains them onto the queue's free port. Sources are served round-robin so that no retire source starves.

## Interface
- `NumTags`, default 8: tag space; `TagWidth = $clog2(NumTags)`.
- `NumSrc`, default 4: number of release sources.
- `NumTagIn`, default 2: tags freed per cycle; matches the tag queue's free width.
- `Depth`, default 8: FIFO entries; power of two, `>= NumTagIn`.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is synchronous and active-low.
- `src_valid_i`, in, `NumSrc`: release request per source.
- `src_tag_i`, in, `NumSrc x TagWidth`: tag to release.
- `src_ready_o`, out, `NumSrc`: request accepted this cycle.
- `free_o`, out, `NumTagIn`: free strobe to the tag queue. Lanes are packed from lane 0.
- `tag_o`, out, `NumTagIn x TagWidth`: tag to free per lane.

## Operation
**State**
- FIFO array, `rd_ptr_q`, `wr_ptr_q` (`$clog2(Depth)` bits, wrap modulo `Depth`).
- `count_q` (`$clog2(Depth+1)` bits).
- Round-robin start `rr_q` (`$clog2(NumSrc)` bits).

**Drain (no backpressure; the tag queue always accepts frees)**
- `n_drain = min(count_q, NumTagIn)`.
- Lane k < `n_drain`: `free_o[k]=1`, `tag_o[k]=fifo[rd_ptr_q+k]`.
- Remaining lanes: `free_o=0`, `tag_o='0`.

**Accept budget**
- Budget = `Depth - count_q`, from registered state only.
- Same-cycle drains are not credited, so there is no combinational path from output to ready.

**Selection**
- Scan sources starting at `rr_q`, wrapping.
- The first `budget` valid sources get `src_ready_o=1`. A valid&ready pair is a handshake.
- Accepted tags are written at `wr_ptr_q`, `wr_ptr_q+1`, … in scan order.
- If at least one source is accepted, `rr_q` becomes (last accepted index + 1) mod `NumSrc`. Otherwise `rr_q` holds.

**Update**
- `count_d = count_q + n_acc - n_drain`.
- Pointers advance by `n_acc` and `n_drain` respectively, both mod `Depth`.

**Boundaries**
- Empty: `free_o='0`; full budget available.
- Full (`count_q==Depth`): all `src_ready_o=0`.
- Pointer wrap: entry order is preserved across the `Depth-1 -> 0` boundary.

**Illegal inputs (simulation assertions, `ifndef SYNTHESIS`)**
- The same tag on two valid sources in one cycle.
- A tag `>= NumTags`.

## Timing
**Reset**
- On a clock edge with `rst_ni=0`: `count_q`, both pointers and `rr_q` go to 0. Buffered tags are discarded.
- While `rst_ni=0`, `src_ready_o` and `free_o` are forced to 0 combinationally; `tag_o='0`.

**Latency**
- Without bypass: a tag accepted in cycle t appears on `free_o` no earlier than t+1.

**Throughput**
- At most `NumTagIn` drained and at most `min(NumSrc, budget)` accepted per cycle.
- Under sustained overload, `count_q` settles at `Depth - NumTagIn`.

**Reset mid-operation**
- No stale tag is emitted after reset.
- Upstream re-issues releases or the tag queue is reset alongside.

## Configuration
**`TAG_RELEASE_BYPASS_EN`**
- **Defined:** lanes left unused by the FIFO drain (`NumTagIn - n_drain`) are filled in the same cycle with accepted tags, in scan order.
  - Bypassed tags are not written to the FIFO.
  - Budget becomes `Depth - count_q + NumTagIn - n_drain`.
  - Zero-cycle latency when the FIFO is empty.
  - FIFO entries always precede bypassed tags on the lanes, which preserves order.
- **Undefined:** pure FIFO behaviour as above, with 1-cycle minimum latency.

## Structure
- `TagWidth` and `tag_t` belong in the dispatcher's shared package `bgpu_dispatcher_pkg`, shared with the tag queue.
- One sub-module: `tag_release_rr_select`, a rotating multi-grant selector.
  - Inputs: valid vector, start index, budget.
  - Outputs: grant vector, per-grant write offset, grant count, next start.

## Test plan
Configuration for all scenarios: `NumTags=8`, `NumSrc=4`, `NumTagIn=2`, `Depth=8`.
1. **Reset:** hold `rst_ni=0` 2 cycles with all sources valid -> `src_ready_o=0`, `free_o=0`. After release: `count_q=0`, `src_ready_o=4'b1111` for valid sources.
2. **Single release:** src2 releases tag 5 at cycle t. Without the macro -> `free_o=2'b01`, `tag_o[0]=5` at t+1. With the macro -> same values at t.
3. **Burst:** FIFO empty, `rr_q=0`, sources 0..3 release tags 0,1,2,3 in one cycle -> all ready. Without the macro -> frees {0,1} at t+1 and {2,3} at t+2.
4. **Overload:** all 4 sources valid every cycle with fresh tags -> `count_q` goes 4, 6, 6…. From cycle 3 exactly 2 sources are ready per cycle. `free_o=2'b11` every cycle. No tag is lost or duplicated (scoreboard).
5. **Fairness:** overload as in 4 for 8 cycles -> grants rotate src{0,1}, {2,3}, {0,1}, …; every source is served at least once every 2 cycles.
6. **Mid-operation reset:** `rst_ni=0` for 1 cycle with `count_q=6` -> next cycle `count_q=0`, `free_o='0`, and none of the 6 buffered tags ever appear on `tag_o`.

Source files
------------

// File: rtl/bgpu_dispatcher_pkg.sv
// bgpu_dispatcher_pkg: shared dispatcher types and defaults (tag space, release-buffer sizing, min helper)
package bgpu_dispatcher_pkg;
  localparam int unsigned DefNumTags  = 8;
  localparam int unsigned DefNumSrc   = 4;
  localparam int unsigned DefNumTagIn = 2;
  localparam int unsigned DefDepth    = 8;
  localparam int unsigned TagWidth    = $clog2(DefNumTags);
  typedef logic [TagWidth-1:0] tag_t;
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/tag_release_rr_select.sv
// tag_release_rr_select: rotating multi-grant selector, grants the first budget_i valid sources scanning from start_i
//   valid_i  : request per source
//   start_i  : scan start index
//   budget_i : maximum number of grants
//   grant_o  : granted sources
//   offset_o : per-grant position in scan order
//   count_o  : number of grants
//   next_o   : index after the last grant (start_i when nothing granted)
module tag_release_rr_select #(
  parameter int unsigned NumSrc = 4,
  parameter int unsigned BudW = 4,
  localparam int unsigned SelW = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic [NumSrc-1:0]           valid_i,
  input  logic [SelW-1:0]             start_i,
  input  logic [BudW-1:0]             budget_i,
  output logic [NumSrc-1:0]           grant_o,
  output logic [NumSrc-1:0][BudW-1:0] offset_o,
  output logic [BudW-1:0]             count_o,
  output logic [SelW-1:0]             next_o
);
  logic [BudW-1:0] cnt;
  logic [SelW-1:0] idx;
  always_comb begin
    grant_o = '0;
    offset_o = '0;
    cnt = '0;
    idx = '0;
    next_o = start_i;
    for (int i = 0; i < NumSrc; i++) begin
      idx = SelW'((int'(start_i) + i) % NumSrc);
      if (valid_i[idx] && cnt < budget_i) begin
        grant_o[idx] = 1'b1;
        offset_o[idx] = cnt;
        cnt = cnt + BudW'(1);
        next_o = SelW'((int'(idx) + 1) % NumSrc);
      end
    end
    count_o = cnt;
  end
endmodule

// File: rtl/tag_release_buffer.sv
// tag_release_buffer: collects tag releases from NumSrc sources round-robin into an in-order FIFO and drains up to NumTagIn per cycle
//   clk_i, rst_ni : clock, synchronous active-low reset
//   src_valid_i / src_tag_i / src_ready_o : per-source release handshake
//   free_o / tag_o : free strobes and tags to the tag queue, packed from lane 0
//   TAG_RELEASE_BYPASS_EN : when defined, idle lanes are filled same-cycle with accepted tags
module tag_release_buffer import bgpu_dispatcher_pkg::*; #(
  parameter int unsigned NumTags = DefNumTags,
  parameter int unsigned NumSrc = DefNumSrc,
  parameter int unsigned NumTagIn = DefNumTagIn,
  parameter int unsigned Depth = DefDepth,
  localparam int unsigned TagW = $clog2(NumTags)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumSrc-1:0]              src_valid_i,
  input  logic [NumSrc-1:0][TagW-1:0]    src_tag_i,
  output logic [NumSrc-1:0]              src_ready_o,
  output logic [NumTagIn-1:0]            free_o,
  output logic [NumTagIn-1:0][TagW-1:0]  tag_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned BudW = $clog2(Depth + NumTagIn + 1);
  localparam int unsigned SelW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

  logic [TagW-1:0]             fifo_q [Depth];
  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [SelW-1:0]             rr_q, rr_d, rr_next;
  logic [BudW-1:0]             n_drain, n_byp, n_acc, n_fifo, budget;
  logic [NumSrc-1:0]           grant;
  logic [NumSrc-1:0][BudW-1:0] offset;

  assign n_drain = BudW'(min_u(int'(count_q), NumTagIn));
`ifdef TAG_RELEASE_BYPASS_EN
  assign n_byp = BudW'(NumTagIn) - n_drain;
`else
  assign n_byp = '0;
`endif
  // Budget comes from registered state only, so ready never depends on the drain path.
  assign budget = rst_ni ? BudW'(Depth) - BudW'(count_q) + n_byp : '0;

  tag_release_rr_select #(
    .NumSrc (NumSrc),
    .BudW   (BudW)
  ) i_select (
    .valid_i  (src_valid_i),
    .start_i  (rr_q),
    .budget_i (budget),
    .grant_o  (grant),
    .offset_o (offset),
    .count_o  (n_acc),
    .next_o   (rr_next)
  );

  assign src_ready_o = grant;
  // The first n_byp accepted tags take the idle lanes; only the rest enter the FIFO.
  assign n_fifo = (n_acc > n_byp) ? n_acc - n_byp : '0;

  always_comb begin
    free_o = '0;
    tag_o = '0;
    for (int k = 0; k < NumTagIn; k++) begin
      if (rst_ni && BudW'(k) < n_drain) begin
        free_o[k] = 1'b1;
        tag_o[k] = fifo_q[rd_ptr_q + PtrW'(k)];
      end
    end
    for (int j = 0; j < NumSrc; j++) begin
      if (grant[j] && offset[j] < n_byp) begin
        free_o[n_drain + offset[j]] = 1'b1;
        tag_o[n_drain + offset[j]] = src_tag_i[j];
      end
    end
  end

  always_comb begin
    count_d = count_q + CntW'(n_fifo) - CntW'(n_drain);
    rd_ptr_d = rd_ptr_q + PtrW'(n_drain);
    wr_ptr_d = wr_ptr_q + PtrW'(n_fifo);
    rr_d = (n_acc != '0) ? rr_next : rr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rr_q <= '0;
    end else begin
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rr_q <= rr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NumSrc; j++) begin
      if (grant[j] && offset[j] >= n_byp) begin
        fifo_q[wr_ptr_q + PtrW'(offset[j] - n_byp)] <= src_tag_i[j];
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      for (int j = 0; j < NumSrc; j++) begin
        assert (!src_valid_i[j] || int'(src_tag_i[j]) < int'(NumTags))
          else $error("tag_release_buffer: source %0d tag %0d out of range", j, src_tag_i[j]);
        for (int k = j + 1; k < NumSrc; k++) begin
          assert (!(src_valid_i[j] && src_valid_i[k] && src_tag_i[j] == src_tag_i[k]))
            else $error("tag_release_buffer: sources %0d and %0d release the same tag", j, k);
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_tag_release_buffer.sv
// tb_tag_release_buffer: directed self-checking bench for tag_release_buffer (NumTags=8, NumSrc=4, NumTagIn=2, Depth=8)
module tb_tag_release_buffer;
  logic clk, rst_n;
  logic [3:0] valid, ready;
  logic [3:0][2:0] tag_in;
  logic [1:0] free;
  logic [1:0][2:0] tag_out;
  int n_chk = 0;
  int n_fail = 0;

  tag_release_buffer #(.NumTags(8), .NumSrc(4), .NumTagIn(2), .Depth(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .src_valid_i (valid),
    .src_tag_i   (tag_in),
    .src_ready_o (ready),
    .free_o      (free),
    .tag_o       (tag_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0;
    valid = '0;
    tag_in = '0;
    tick;
    rst_n = 1;
  endtask

  task automatic overload_inputs(inout logic [2:0] base);
    valid = 4'hf;
    for (int j = 0; j < 4; j++) tag_in[j] = base + 3'(j);
    base = base + 3'd4;
  endtask

  task automatic test_reset;
    rst_n = 0;
    valid = 4'hf;
    for (int j = 0; j < 4; j++) tag_in[j] = 3'(j);
    tick;
    tick;
    n_chk++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", ready); end
    n_chk++; if (free !== 2'b00) begin n_fail++; $display("FAIL reset_free: got %b want 00", free); end
    n_chk++; if (tag_out !== 6'd0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", tag_out); end
    rst_n = 1;
    #1;
    n_chk++; if (dut.count_q !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
    n_chk++; if (ready !== 4'b1111) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1111", ready); end
    valid = '0;
  endtask

  task automatic test_single;
    valid = 4'b0100;
    tag_in = '0;
    tag_in[2] = 3'd5;
    #1;
    n_chk++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", ready); end
    n_chk++; if (free !== 2'b00) begin n_fail++; $display("FAIL single_latency: got %b want 00", free); end
    tick;
    valid = '0;
    #1;
    n_chk++; if (free !== 2'b01) begin n_fail++; $display("FAIL single_free: got %b want 01", free); end
    n_chk++; if (tag_out[0] !== 3'd5) begin n_fail++; $display("FAIL single_tag0: got %0d want 5", tag_out[0]); end
    n_chk++; if (tag_out[1] !== 3'd0) begin n_fail++; $display("FAIL single_tag1: got %0d want 0", tag_out[1]); end
    tick;
    n_chk++; if (free !== 2'b00) begin n_fail++; $display("FAIL single_empty: got %b want 00", free); end
  endtask

  task automatic test_burst;
    do_reset;
    valid = 4'hf;
    for (int j = 0; j < 4; j++) tag_in[j] = 3'(j);
    #1;
    n_chk++; if (ready !== 4'b1111) begin n_fail++; $display("FAIL burst_ready: got %b want 1111", ready); end
    tick;
    valid = '0;
    #1;
    n_chk++; if (free !== 2'b11 || tag_out[0] !== 3'd0 || tag_out[1] !== 3'd1)
      begin n_fail++; $display("FAIL burst_first: got free %b tags %0d,%0d want 11 0,1", free, tag_out[0], tag_out[1]); end
    tick;
    n_chk++; if (free !== 2'b11 || tag_out[0] !== 3'd2 || tag_out[1] !== 3'd3)
      begin n_fail++; $display("FAIL burst_second: got free %b tags %0d,%0d want 11 2,3", free, tag_out[0], tag_out[1]); end
    tick;
    n_chk++; if (free !== 2'b00) begin n_fail++; $display("FAIL burst_drained: got %b want 00", free); end
  endtask

  task automatic test_overload;
    logic [2:0] sb[$];
    logic [2:0] base;
    logic [3:0] exp_rdy;
    logic [1:0] exp_free;
    int exp_cnt;
    do_reset;
    base = '0;
    for (int c = 0; c < 10; c++) begin
      overload_inputs(base);
      #1;
      exp_rdy = (c < 2) ? 4'b1111 : ((c % 2 == 0) ? 4'b0011 : 4'b1100);
      exp_free = (c == 0) ? 2'b00 : 2'b11;
      n_chk++; if (ready !== exp_rdy) begin n_fail++; $display("FAIL overload_ready c%0d: got %b want %b", c, ready, exp_rdy); end
      n_chk++; if (free !== exp_free) begin n_fail++; $display("FAIL overload_free c%0d: got %b want %b", c, free, exp_free); end
      for (int k = 0; k < 2; k++) begin
        if (exp_free[k]) begin
          n_chk++;
          if (sb.size() == 0) begin n_fail++; $display("FAIL overload_sb c%0d lane%0d: got %0d want none", c, k, tag_out[k]); end
          else begin
            if (tag_out[k] !== sb[0]) begin n_fail++; $display("FAIL overload_tag c%0d lane%0d: got %0d want %0d", c, k, tag_out[k], sb[0]); end
            void'(sb.pop_front());
          end
        end
      end
      for (int j = 0; j < 4; j++) if (exp_rdy[j]) sb.push_back(tag_in[j]);
      tick;
      exp_cnt = (c == 0) ? 4 : 6;
      n_chk++; if (dut.count_q !== 4'(exp_cnt)) begin n_fail++; $display("FAIL overload_count c%0d: got %0d want %0d", c, dut.count_q, exp_cnt); end
    end
    valid = '0;
  endtask

  task automatic test_fairness;
    logic [2:0] base;
    logic [3:0] prev;
    do_reset;
    base = '0;
    prev = '0;
    for (int c = 0; c < 8; c++) begin
      overload_inputs(base);
      #1;
      if (c >= 2) begin
        n_chk++; if ($countones(ready) != 2) begin n_fail++; $display("FAIL fair_count c%0d: got %b want two grants", c, ready); end
        n_chk++; if ((ready | prev) !== 4'b1111) begin n_fail++; $display("FAIL fair_gap c%0d: got %b prev %b want every source within 2 cycles", c, ready, prev); end
      end
      prev = ready;
      tick;
    end
    valid = '0;
  endtask

  task automatic test_mid_reset;
    logic [2:0] base;
    do_reset;
    base = '0;
    for (int c = 0; c < 3; c++) begin
      overload_inputs(base);
      tick;
    end
    n_chk++; if (dut.count_q !== 4'd6) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 6", dut.count_q); end
    rst_n = 0;
    valid = '0;
    #1;
    n_chk++; if (free !== 2'b00) begin n_fail++; $display("FAIL midrst_free_low: got %b want 00", free); end
    tick;
    rst_n = 1;
    #1;
    n_chk++; if (dut.count_q !== 4'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", dut.count_q); end
    n_chk++; if (free !== 2'b00) begin n_fail++; $display("FAIL midrst_free: got %b want 00", free); end
    valid = 4'b0011;
    tag_in = '0;
    tag_in[0] = 3'd2;
    tag_in[1] = 3'd3;
    tick;
    valid = '0;
    #1;
    n_chk++; if (free !== 2'b11 || tag_out[0] !== 3'd2 || tag_out[1] !== 3'd3)
      begin n_fail++; $display("FAIL midrst_new: got free %b tags %0d,%0d want 11 2,3", free, tag_out[0], tag_out[1]); end
    for (int c = 0; c < 4; c++) begin
      tick;
      n_chk++; if (free !== 2'b00) begin n_fail++; $display("FAIL midrst_stale c%0d: got free %b tags %h want 00", c, free, tag_out); end
    end
  endtask

  initial begin
    rst_n = 0;
    valid = '0;
    tag_in = '0;
    test_reset;
    test_single;
    test_burst;
    test_overload;
    test_fairness;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
